// File: rtl/sfx_scheduler.sv
// Sound-effect arbiter: latches eat/hit/die request edges and plays one effect at a time
// on the APU trigger lines, frame-timed, with fixed priority die > hit > eat and a silent gap.
module sfx_scheduler #(
    parameter int EAT_FRAMES = 8,
    parameter int HIT_FRAMES = 6,
    parameter int DIE_FRAMES = 30,
    parameter int GAP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       req_eat,
    input  logic       req_hit,
    input  logic       req_die,
    input  logic       mute,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [1:0] ID_NONE = 2'd0;

    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [1:0] act, act_n;
    logic [2:0] pending, pending_n;
    logic [2:0] req_q;
    logic [2:0] edges, grant_mask, retrig_mask;
    logic [1:0] top_id;
    logic [2:0] trig_n;
    logic       busy_n;
    logic [1:0] active_id_n;

    // Pending bit index is id-1: bit0 eat, bit1 hit, bit2 die.
    function automatic logic [2:0] onehot(input logic [1:0] id);
        return (id == ID_NONE) ? 3'b000 : (3'b001 << (id - 2'd1));
    endfunction

    function automatic logic [5:0] dur(input logic [1:0] id);
        case (id)
            2'd1:    return 6'(EAT_FRAMES);
            2'd2:    return 6'(HIT_FRAMES);
            2'd3:    return 6'(DIE_FRAMES);
            default: return 6'd0;
        endcase
    endfunction

    assign edges  = {req_die, req_hit, req_eat} & ~req_q;
    assign top_id = pending[2] ? 2'd3 : pending[1] ? 2'd2 : pending[0] ? 2'd1 : ID_NONE;

    // State register: FSM, counter, pending latch, edge regs and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 6'd0;
            act            <= ID_NONE;
            pending        <= 3'b000;
            req_q          <= 3'b000;
            saw_trigger    <= 1'b0;
            square_trigger <= 1'b0;
            noise_trigger  <= 1'b0;
            busy           <= 1'b0;
            active_id      <= ID_NONE;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            act            <= act_n;
            pending        <= pending_n;
            req_q          <= {req_die, req_hit, req_eat};
            saw_trigger    <= trig_n[0];
            square_trigger <= trig_n[1];
            noise_trigger  <= trig_n[2];
            busy           <= busy_n;
            active_id      <= active_id_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        act_n       = act;
        grant_mask  = 3'b000;
        retrig_mask = 3'b000;
        case (state)
            IDLE: begin
                if (top_id != ID_NONE) begin
                    grant_mask = onehot(top_id);
                    act_n      = top_id;
                    cnt_n      = dur(top_id);
                    state_n    = PLAY;
                end
            end
            PLAY: begin
                retrig_mask = onehot(act);
                if (top_id > act) begin
                    // Preempted effect is simply dropped, never requeued.
                    grant_mask = onehot(top_id);
                    act_n      = top_id;
                    cnt_n      = dur(top_id);
                end else if ((edges & onehot(act)) != 3'b000) begin
                    cnt_n = dur(act);
                end else if (frame_end) begin
                    if (cnt == 6'd1) begin
                        if (GAP_FRAMES == 0) begin
                            state_n = IDLE;
                            act_n   = ID_NONE;
                        end else begin
                            state_n = GAP;
                            cnt_n   = 6'(GAP_FRAMES);
                        end
                    end else begin
                        cnt_n = cnt - 6'd1;
                    end
                end
            end
            GAP: begin
                if (frame_end) begin
                    if (cnt == 6'd1) begin
                        state_n = IDLE;
                        act_n   = ID_NONE;
                    end else begin
                        cnt_n = cnt - 6'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                act_n   = ID_NONE;
            end
        endcase
        pending_n = (pending & ~grant_mask) | (edges & ~retrig_mask);
    end

    // Output logic: next values of the registered outputs; mute only gates the triggers.
    always_comb begin
        trig_n      = 3'b000;
        busy_n      = (state_n != IDLE);
        active_id_n = (state_n == IDLE) ? ID_NONE : act_n;
        if (state_n == PLAY && !mute)
            trig_n = onehot(act_n);
    end

endmodule
